// File: rtl/pulse_gen.sv
// pulse_gen: step/direction pulse generator for the six-axis stepper chain.
//
// It accepts one command at a time from the motion control block. The command
// is the triple {MotorOut, PulseNum, DROut}. For each command it:
//   - loads the selected motor's DIR bit,
//   - waits DIR_SETUP cycles,
//   - emits PulseNum step pulses on that motor's PUL line. Each pulse is
//     HALF_PERIOD cycles high, then HALF_PERIOD cycles low.
// A command is accepted only when the triple has changed since the last move.
//
// Ports:
//   sysclk    in  1   system clock
//   rst       in  1   synchronous reset, active low
//   MotorOut  in  6   one-hot motor select
//   PulseNum  in  10  number of step pulses, 0..1023
//   DROut     in  6   direction vector (1 = reverse), selected bit used
//   Busy      out 1   high while a move executes
//   PUL       out 6   step pulse lines
//   DIR       out 6   direction lines, held between moves
//   Done      out 1   one-cycle strobe at the end of the last low phase
module pulse_gen #(
  parameter int unsigned HALF_PERIOD = 2500,
  parameter int unsigned DIR_SETUP   = 250
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [5:0] MotorOut,
  input  logic [9:0] PulseNum,
  input  logic [5:0] DROut,
  output logic       Busy,
  output logic [5:0] PUL,
  output logic [5:0] DIR,
  output logic       Done
);

  localparam int unsigned NM = 6;   // motors
  localparam int unsigned NW = 10;  // pulse count width
  localparam int unsigned PW = 16;  // phase counter width

  localparam logic [PW-1:0] SETUP_LOAD = PW'(DIR_SETUP - 1);
  localparam logic [PW-1:0] HALF_LOAD  = PW'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW
  } state_t;

  state_t        state;
  logic [NM-1:0] mot_q;
  logic [NW-1:0] num_q;
  logic [NM-1:0] dr_q;
  logic [NW-1:0] pulse_cnt;
  logic [PW-1:0] phase;

  logic onehot_c;
  logic changed_c;
  logic accept_c;

  // Command qualification: a new, well-formed triple is required.
  // The upstream block holds its outputs between moves, so a triple that
  // matches the last accepted one is never re-executed.
  assign onehot_c  = (MotorOut != '0) && ((MotorOut & (MotorOut - NM'(1))) == '0);
  assign changed_c = ({MotorOut, PulseNum, DROut} != {mot_q, num_q, dr_q});
  assign accept_c  = onehot_c && changed_c && (PulseNum != '0);

  // Sequencer: direction setup, then alternating high/low phases per pulse.
  always_ff @(posedge sysclk) begin
    if (!rst) begin
      state     <= IDLE;
      mot_q     <= '0;
      num_q     <= '0;
      dr_q      <= '0;
      pulse_cnt <= '0;
      phase     <= '0;
      Busy      <= 1'b0;
      PUL       <= '0;
      DIR       <= '0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            state     <= SETUP;
            Busy      <= 1'b1;
            mot_q     <= MotorOut;
            num_q     <= PulseNum;
            dr_q      <= DROut;
            // Only the selected motor's direction moves; the others hold.
            DIR       <= (DIR & ~MotorOut) | (DROut & MotorOut);
            phase     <= SETUP_LOAD;
            pulse_cnt <= '0;
          end
        end
        SETUP: begin
          if (phase == '0) begin
            state <= HIGH;
            PUL   <= mot_q;
            phase <= HALF_LOAD;
          end else begin
            phase <= phase - PW'(1);
          end
        end
        HIGH: begin
          if (phase == '0) begin
            state     <= LOW;
            PUL       <= '0;
            pulse_cnt <= pulse_cnt + NW'(1);
            phase     <= HALF_LOAD;
          end else begin
            phase <= phase - PW'(1);
          end
        end
        LOW: begin
          if (phase == '0) begin
            if (pulse_cnt == num_q) begin
              state <= IDLE;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end else begin
              state <= HIGH;
              PUL   <= mot_q;
              phase <= HALF_LOAD;
            end
          end else begin
            phase <= phase - PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: directed self-checking bench for pulse_gen.
// It uses HALF_PERIOD=2 and DIR_SETUP=3. Outputs are sampled 1 time unit
// after each rising edge of sysclk.
module tb_pulse_gen;

  localparam int unsigned H = 2;
  localparam int unsigned D = 3;

  logic       sysclk;
  logic       rst;
  logic [5:0] MotorOut;
  logic [9:0] PulseNum;
  logic [5:0] DROut;
  logic       Busy;
  logic [5:0] PUL;
  logic [5:0] DIR;
  logic       Done;

  int total;
  int bad;

  pulse_gen #(
    .HALF_PERIOD(H),
    .DIR_SETUP  (D)
  ) dut (
    .sysclk  (sysclk),
    .rst     (rst),
    .MotorOut(MotorOut),
    .PulseNum(PulseNum),
    .DROut   (DROut),
    .Busy    (Busy),
    .PUL     (PUL),
    .DIR     (DIR),
    .Done    (Done)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  // Check {Busy, Done, PUL, DIR} cycle by cycle from the cycle after the accept
  // edge. It runs through the Done cycle, or stops after cycle stop_at if
  // stop_at >= 0.
  task automatic expect_move(input logic [5:0] mot, input int n, input logic [5:0] dir_exp,
                             input int stop_at, input string tag);
    int          tot;
    int          last;
    logic        b;
    logic        d;
    logic [5:0]  p;
    tot  = int'(D) + 2 * int'(H) * n;
    last = (stop_at >= 0) ? stop_at : tot;
    for (int i = 0; i <= last; i++) begin
      if (i < tot) begin
        b = 1'b1;
        d = 1'b0;
        p = (i >= int'(D) && ((i - int'(D)) % (2 * int'(H))) < int'(H)) ? mot : 6'b0;
      end else begin
        b = 1'b0;
        d = 1'b1;
        p = 6'b0;
      end
      chk($sformatf("%s_c%0d", tag, i), {2'b0, Busy, Done, PUL, DIR}, {2'b0, b, d, p, dir_exp});
      if (i < last) step();
    end
  endtask

  // Hold idle for ncyc cycles, expecting no activity and a fixed DIR.
  task automatic expect_idle(input int ncyc, input logic [5:0] dir_exp, input string tag);
    for (int i = 0; i < ncyc; i++) begin
      step();
      chk($sformatf("%s_c%0d", tag, i), {2'b0, Busy, Done, PUL, DIR}, {4'b0, 6'b0, dir_exp});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b0;
    MotorOut = '0;
    PulseNum = '0;
    DROut    = '0;
    step();
    step();
    chk("rst_busy", {15'b0, Busy}, 16'h0);
    chk("rst_pul",  {10'b0, PUL},  16'h0);
    chk("rst_dir",  {10'b0, DIR},  16'h0);
    chk("rst_done", {15'b0, Done}, 16'h0);

    // An all-zero triple matches the cleared latch: nothing starts.
    rst = 1'b1;
    expect_idle(3, 6'b000000, "zero_idle");

    // 1. Single move on motor 0: 3 pulses, forward.
    MotorOut = 6'b000001; PulseNum = 10'd3; DROut = 6'b000000;
    step();
    expect_move(6'b000001, 3, 6'b000000, -1, "s1");

    // 2. Direction isolation on motor 2. Accepted on the edge after Done.
    MotorOut = 6'b000100; PulseNum = 10'd1; DROut = 6'b000100;
    step();
    expect_move(6'b000100, 1, 6'b000100, -1, "s2");

    // 3. Unchanged triple is never re-executed.
    expect_idle(50, 6'b000100, "s3_hold");

    // 4. Invalid commands are ignored.
    MotorOut = 6'b000011; PulseNum = 10'd5; DROut = 6'b000011;
    expect_idle(8, 6'b000100, "s4_multi");
    MotorOut = 6'b001000; PulseNum = 10'd0; DROut = 6'b001000;
    expect_idle(8, 6'b000100, "s4_zero_n");
    MotorOut = 6'b000000; PulseNum = 10'd5; DROut = 6'b111111;
    expect_idle(8, 6'b000100, "s4_no_mot");

    // 5. Pending command: the new triple appears on the edge Busy rises.
    MotorOut = 6'b010000; PulseNum = 10'd1; DROut = 6'b000000;
    step();
    MotorOut = 6'b100000; PulseNum = 10'd2; DROut = 6'b100000;
    expect_move(6'b010000, 1, 6'b000100, -1, "s5_m4");
    step();
    expect_move(6'b100000, 2, 6'b100100, -1, "s5_m5");

    // 6. Reset during the second HIGH phase of a 4-pulse move.
    step();
    MotorOut = 6'b000010; PulseNum = 10'd4; DROut = 6'b000010;
    step();
    expect_move(6'b000010, 4, 6'b100110, 7, "s6_pre");
    rst = 1'b0;
    step();
    chk("s6_rst", {2'b0, Busy, Done, PUL, DIR}, 16'h0);
    step();
    chk("s6_rst_hold", {2'b0, Busy, Done, PUL, DIR}, 16'h0);
    rst = 1'b1;
    step();
    expect_move(6'b000010, 4, 6'b000010, -1, "s6_fresh");
    expect_idle(5, 6'b000010, "s6_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
